// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler produces a base tick, and four programmable
// channels derive periodic one-cycle tick strobes from it.
module tick_scheduler #(
   parameter int unsigned CLK_DIV  = 100000,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                sync_all,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_addr,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic                base_tick,
   output logic [3:0]          tick,
   output logic [3:0]          active
);

   localparam logic [23:0]         DIV_LAST = 24'(CLK_DIV - 1);
   localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1);

   logic [23:0]         cnt_q, cnt_d;
   logic                base_q, base_d;
   logic [PERIOD_W-1:0] period_q [4];
   logic [PERIOD_W-1:0] period_d [4];
   logic [PERIOD_W-1:0] chcnt_q  [4];
   logic [PERIOD_W-1:0] chcnt_d  [4];
   logic [3:0]          tick_q, tick_d;
   logic [3:0]          active_q, active_d;
   logic                upd;

   always_comb begin
      cnt_d    = cnt_q;
      base_d   = 1'b0;
      period_d = period_q;
      chcnt_d  = chcnt_q;
      tick_d   = '0;
      active_d = '0;
      upd      = base_q & run;

      if (sync_all) begin
         cnt_d = '0;
         for (int unsigned i = 0; i < 4; i++) chcnt_d[i] = '0;
      end else begin
         if (run) begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               base_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         // A write to a channel overrides that channel's update on the same edge.
         for (int unsigned i = 0; i < 4; i++) begin
            if (cfg_we && cfg_addr == 2'(i)) begin
               period_d[i] = cfg_period;
               chcnt_d[i]  = '0;
            end else if (upd && period_q[i] != '0) begin
               if (chcnt_q[i] == period_q[i] - P_ONE) begin
                  chcnt_d[i] = '0;
                  tick_d[i]  = 1'b1;
               end else begin
                  chcnt_d[i] = chcnt_q[i] + P_ONE;
               end
            end
         end
      end

      for (int unsigned i = 0; i < 4; i++) active_d[i] = (period_d[i] != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         base_q   <= 1'b0;
         tick_q   <= '0;
         active_q <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            period_q[i] <= '0;
            chcnt_q[i]  <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         tick_q   <= tick_d;
         active_q <= active_d;
         period_q <= period_d;
         chcnt_q  <= chcnt_d;
      end
   end

   assign base_tick = base_q;
   assign tick      = tick_q;
   assign active    = active_q;

endmodule
